module_ram_responder: RTL
=========================

// Module: module_ram_responder
// PURPOSE
//  256x8 RAM that is the memory side of the CPU data bus (addr/wdata/write_en -> rdata).
//  Serves CPU reads and writes one slave-clock step at a time, matching the CPU's
//  fetch sequence: address in step N, data sampled in step N+2 (N+1 for operand bytes).
//  A byte-stream loader FSM writes a program image before/between runs and holds the CPU.
// PARAMETERS
//  ADDR_W   8  address width; depth = 2**ADDR_W, all address arithmetic mod 2**ADDR_W
//  DATA_W   8  data width
// PORTS
//  clk_qzt    in   1       system clock, all state on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  en         in   1       global enable; when 0, the step detector and CPU writes freeze
//  clk_in     in   1       slave step clock (level), rising edge detected on clk_qzt
//  mem_addr   in   ADDR_W  CPU address (CPU data_addr)
//  mem_wdata  in   DATA_W  CPU write data (CPU data_out)
//  write_en   in   1       CPU write request, 1 = write
//  mem_rdata  out  DATA_W  read data to CPU (CPU data_in)
//  ld_start   in   1       1-cycle pulse: begin load at ld_base
//  ld_base    in   ADDR_W  first load address
//  ld_len     in   ADDR_W+1 byte count, 1..2**ADDR_W (0 = no-op, returns to IDLE)
//  ld_valid   in   1       loader byte present
//  ld_data    in   DATA_W  loader byte
//  ld_ready   out  1       loader can accept a byte (1 only in LOAD)
//  ld_done    out  1       1-cycle pulse after the last byte is written
//  cpu_hold   out  1       1 while the loader owns the RAM; drives CPU en low externally
// BEHAVIOUR
//  Reset: mem_rdata=0, ld_ready=0, ld_done=0, cpu_hold=0, FSM=IDLE, step detector=0.
//   Array contents are NOT reset.
//  Step detect: step = en & clk_in & ~clk_in_q; clk_in_q updates only when en=1.
//  Read: mem_rdata <= mem[mem_addr] on every clk_qzt edge (1 qzt-cycle latency),
//   so data is stable before the next slave step. Read-during-write returns old data
//   for one cycle, then new data.
//  CPU write: mem[mem_addr] <= mem_wdata on a step with write_en=1 and FSM=IDLE.
//   Exactly one write per step. Writes are ignored in LOAD/DONE.
//  Loader FSM:
//   IDLE -ld_start & ld_len!=0-> LOAD; ptr=ld_base, cnt=ld_len, cpu_hold=1.
//   LOAD: ld_ready=1; on ld_valid: mem[ptr]<=ld_data, ptr=ptr+1 (wraps 0xFF->0x00),
//     cnt-1; when the last byte is accepted -> DONE.
//   DONE: ld_done=1 for one cycle, cpu_hold=0, -> IDLE.
//   ld_start in LOAD/DONE is ignored. ld_len > depth is clamped to depth.
//  Simultaneous loader byte and CPU write step: the loader wins; the CPU write is dropped.
//  reset_n low mid-load: FSM->IDLE, cpu_hold=0 immediately; bytes already written remain.
// CONFIGURATION
//  RAM_WPROT_EN defined: a write-protect window [wp_lo, wp_hi] is latched on entry to DONE
//   (wp_lo=ld_base, wp_hi=last written address, possibly wrapped).
//   CPU writes inside the window are dropped. Extra output wp_err (1 bit, reset 0) is a
//   sticky flag set on a dropped write and cleared by the next ld_start. The window is
//   cleared by reset.
//  RAM_WPROT_EN undefined: no window and no wp_err port; all IDLE CPU writes are committed.
// TESTING
//  Load len=4 at 0x10: 06 05 80 00 -> ld_ready 4 cycles, ld_done 1 pulse, mem[0x10..0x13] match.
//  After load, addr=0x12, one step -> mem_rdata=0x80 within 1 qzt cycle, held until addr changes.
//  write_en=1, addr=0x40, wdata=0xA5, two qzt edges with clk_in high once -> exactly one write;
//   a read returns 0xA5.
//  Load len=3 at 0xFE -> bytes land at 0xFE, 0xFF, 0x00; ld_done pulses once.
//  CPU write step in the same cycle as a loader byte -> loader data kept, CPU write absent.
//  RAM_WPROT_EN: after loading 0x10..0x13, CPU write to 0x11 -> mem unchanged, wp_err=1;
//   write to 0x14 -> committed. reset_n low mid-load -> cpu_hold=0 and FSM IDLE at once.

Source files
------------

// File: rtl/module_ram_responder.sv
// 256x8 CPU data RAM with a byte-stream program loader that holds the CPU while it owns the array.
// Reads: 1 clk_qzt latency. Loader: ld_ready/ld_valid, one byte per cycle. Optional RAM_WPROT_EN adds a write-protect window.
module module_ram_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_qzt,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              write_en,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
`ifdef RAM_WPROT_EN
  output logic              wp_err,
`endif
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_clamped;
  logic              clk_in_q;
  logic              step;
  logic              start_load;
  logic              ld_write;
  logic              last_byte;
  logic              cpu_write_req;
  logic              cpu_write;

  logic [DATA_W-1:0] mem [DEPTH];

  assign step          = en & clk_in & ~clk_in_q;
  assign len_clamped   = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
  assign start_load    = (state == IDLE) && ld_start && (ld_len != '0);
  assign ld_write      = (state == LOAD) && ld_valid;
  assign last_byte     = ld_write && (cnt == ONE_L);
  // CPU writes only land in IDLE, so a loader byte always wins the array.
  assign cpu_write_req = step && write_en && (state == IDLE);

`ifdef RAM_WPROT_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] wp_lo;
  logic [ADDR_W-1:0] wp_hi;
  logic              wp_vld;
  logic              in_window;

  // Window may wrap past the top of the array, in which case lo > hi.
  always_comb begin
    in_window = 1'b0;
    if (wp_vld) begin
      if (wp_lo <= wp_hi)
        in_window = (mem_addr >= wp_lo) && (mem_addr <= wp_hi);
      else
        in_window = (mem_addr >= wp_lo) || (mem_addr <= wp_hi);
    end
  end

  assign cpu_write = cpu_write_req && !in_window;

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      wp_lo  <= '0;
      wp_hi  <= '0;
      wp_vld <= 1'b0;
      wp_err <= 1'b0;
    end else begin
      if (start_load)
        base_q <= ld_base;
      if ((state == IDLE) && ld_start)
        wp_err <= 1'b0;
      else if (cpu_write_req && in_window)
        wp_err <= 1'b1;
      if (last_byte) begin
        wp_vld <= 1'b1;
        wp_lo  <= base_q;
        wp_hi  <= ptr;
      end
    end
  end
`else
  assign cpu_write = cpu_write_req;
`endif

  always_ff @(posedge clk_qzt) begin
    if (ld_write)
      mem[ptr] <= ld_data;
    else if (cpu_write)
      mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      ld_ready  <= 1'b0;
      ld_done   <= 1'b0;
      cpu_hold  <= 1'b0;
      clk_in_q  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (en)
        clk_in_q <= clk_in;
      mem_rdata <= mem[mem_addr];
      case (state)
        IDLE: begin
          if (start_load) begin
            state    <= LOAD;
            ptr      <= ld_base;
            cnt      <= len_clamped;
            ld_ready <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_write) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (last_byte) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end
        DONE: begin
          ld_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
